// File: rtl/prog_clk_div_if.sv
// Control/status bundle for prog_clk_div: requested timing, strobes and the
// divided-clock outputs. clk/rst stay outside as plain ports.
interface prog_clk_div_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic [WIDTH-1:0] high_in;
  logic             load;
  logic             sync_clr;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic             pending;

  modport master (
    output en, div_in, high_in, load, sync_clr,
    input  clk_out, tick, cnt, pending
  );

  modport slave (
    input  en, div_in, high_in, load, sync_clr,
    output clk_out, tick, cnt, pending
  );
endinterface

// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider with duty control. New period/high-time
// values are double-buffered and only take effect at a period boundary.
module prog_clk_div #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_DIV  = 500,
  parameter int unsigned DEFAULT_HIGH = 250
) (
  input  logic            clk,
  input  logic            rst,
  prog_clk_div_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] p_q, h_q, pd_q, hd_q;
  logic [WIDTH-1:0] cnt_q;
  logic             pending_q, clk_out_q, tick_q;

  logic [WIDTH-1:0] ld_div_d, src_p_d, src_h_d, cnt_d;
  logic             wrap_d, apply_d;

  always_comb begin
    ld_div_d = (bus.div_in < WIDTH'(2)) ? WIDTH'(2) : bus.div_in;
    // A same-cycle load beats any older pending pair.
    if (bus.load) begin
      src_p_d = ld_div_d;
      src_h_d = bus.high_in;
    end else if (pending_q) begin
      src_p_d = pd_q;
      src_h_d = hd_q;
    end else begin
      src_p_d = p_q;
      src_h_d = h_q;
    end
    wrap_d  = (cnt_q == p_q - WIDTH'(1));
    cnt_d   = wrap_d ? '0 : cnt_q + WIDTH'(1);
    apply_d = 1'b0;
    if (state_q == IDLE)
      apply_d = bus.en | pending_q;
    else
      apply_d = bus.en & (bus.sync_clr | wrap_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      p_q       <= WIDTH'(DEFAULT_DIV);
      h_q       <= WIDTH'(DEFAULT_HIGH);
      pd_q      <= WIDTH'(DEFAULT_DIV);
      hd_q      <= WIDTH'(DEFAULT_HIGH);
    end else begin
      if (apply_d) begin
        p_q       <= src_p_d;
        h_q       <= src_h_d;
        pd_q      <= src_p_d;
        hd_q      <= src_h_d;
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pd_q      <= ld_div_d;
        hd_q      <= bus.high_in;
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          tick_q    <= 1'b0;
          clk_out_q <= 1'b0;
          if (bus.en) begin
            state_q   <= RUN;
            tick_q    <= 1'b1;
            clk_out_q <= (src_h_d != '0);
          end
        end
        RUN: begin
          if (!bus.en) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
          end else if (bus.sync_clr) begin
            cnt_q     <= '0;
            tick_q    <= 1'b1;
            clk_out_q <= (src_h_d != '0);
          end else begin
            cnt_q     <= cnt_d;
            tick_q    <= wrap_d;
            // At a wrap the freshly applied high time governs position 0.
            clk_out_q <= wrap_d ? (src_h_d != '0) : (cnt_d < h_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pending_q;

endmodule
